rr_onehot_arbiter: RTL

- Four-requester round-robin arbiter.
- Produces a registered, strictly one-hot grant vector that feeds the downstream 4:2 encoder directly.
- Guarantees the encoder never sees zero-hot or multi-hot input while gnt_valid=1.
- Holds each grant until the owner releases it or a hold timeout expires, then rotates priority.

---
 rtl/rr_onehot_arbiter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/rr_onehot_arbiter.sv
// rr_onehot_arbiter: four-requester round-robin arbiter with a registered,
// strictly one-hot grant, a hold-time limit and a timeout pulse.
// Optional build macro: ARB_FAST_REGRANT_EN (re-grant on the release edge
// without an idle cycle when another requester is waiting).
module rr_onehot_arbiter #(
  parameter int unsigned HOLD_MAX = 15,
  parameter int unsigned CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       release_i,
  output logic [3:0] gnt,
  output logic       gnt_valid,
  output logic       timeout
);

  localparam int unsigned N_REQ = 4;
  localparam int unsigned PTR_W = 2;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

  // Reject hold limits the counter cannot represent
  generate
    if (HOLD_MAX < 1 || HOLD_MAX > (2 ** CNT_W) - 1) begin : g_bad_hold_max
      $error("rr_onehot_arbiter: HOLD_MAX=%0d outside 1..%0d", HOLD_MAX, (2 ** CNT_W) - 1);
    end
  endgenerate

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t             r_state;
  logic [PTR_W-1:0]   r_ptr;
  logic [CNT_W-1:0]   r_cnt;
  logic [N_REQ-1:0]   r_gnt;
  logic               r_gnt_valid;
  logic               r_timeout;

  state_t             w_state_nxt;
  logic [PTR_W-1:0]   w_ptr_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [N_REQ-1:0]   w_gnt_nxt;
  logic               w_timeout_nxt;

  logic [PTR_W-1:0]   w_owner;
  logic [PTR_W-1:0]   w_ptr_after;
  logic               w_owner_req;
  logic               w_at_limit;
  logic               w_release;
  logic               w_timeout_hit;

  // First set bit of vec in the order ptr, ptr+1, ptr+2, ptr+3 (mod 4)
  function automatic logic [N_REQ-1:0] f_pick(input logic [PTR_W-1:0] ptr,
                                               input logic [N_REQ-1:0] vec);
    logic [N_REQ-1:0] g;
    logic             found;
    logic [PTR_W-1:0] idx;
    g     = '0;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = ptr + PTR_W'(k);
      if (!found && vec[idx]) begin
        g[idx] = 1'b1;
        found  = 1'b1;
      end
    end
    return g;
  endfunction

  // Encode the current one-hot owner to an index
  always_comb begin
    w_owner = '0;
    case (r_gnt)
      4'b0010: w_owner = 2'd1;
      4'b0100: w_owner = 2'd2;
      4'b1000: w_owner = 2'd3;
      default: w_owner = 2'd0;
    endcase
  end

  assign w_ptr_after   = w_owner + PTR_W'(1);
  assign w_owner_req   = |(req & r_gnt);
  assign w_at_limit    = (r_cnt == HOLD_LAST);
  assign w_release     = release_i | ~w_owner_req | w_at_limit;
  assign w_timeout_hit = w_at_limit & ~release_i & w_owner_req;

`ifdef ARB_FAST_REGRANT_EN
  logic [N_REQ-1:0] w_masked;
  assign w_masked = req & ~r_gnt;
`endif

  // Next-state, pointer, hold counter and grant selection
  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_cnt_nxt     = r_cnt;
    w_gnt_nxt     = r_gnt;
    w_timeout_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|req) begin
          w_gnt_nxt   = f_pick(r_ptr, req);
          w_cnt_nxt   = '0;
          w_state_nxt = S_GRANT;
        end else begin
          w_gnt_nxt = '0;
        end
      end
      S_GRANT: begin
        if (w_release) begin
          w_ptr_nxt     = w_ptr_after;
          w_timeout_nxt = w_timeout_hit;
          w_gnt_nxt     = '0;
          w_cnt_nxt     = '0;
          w_state_nxt   = S_IDLE;
`ifdef ARB_FAST_REGRANT_EN
          if (|w_masked) begin
            w_gnt_nxt   = f_pick(w_ptr_after, w_masked);
            w_state_nxt = S_GRANT;
          end
`endif
        end else if (r_cnt != {CNT_W{1'b1}}) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_gnt_nxt   = '0;
      end
    endcase
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_cnt       <= '0;
      r_gnt       <= '0;
      r_gnt_valid <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ptr       <= w_ptr_nxt;
      r_cnt       <= w_cnt_nxt;
      r_gnt       <= w_gnt_nxt;
      r_gnt_valid <= |w_gnt_nxt;
      r_timeout   <= w_timeout_nxt;
    end
  end

  assign gnt       = r_gnt;
  assign gnt_valid = r_gnt_valid;
  assign timeout   = r_timeout;

endmodule
